// File: rtl/alu_pkg.sv
// Shared constants and op encodings for the ALU-sharing arbiter.
package alu_pkg;

  localparam int unsigned ALU_WIDTH   = 32;
  localparam int unsigned ALU_SEL_W   = 3;
  localparam int unsigned ALU_NUM_OPS = 8;

  typedef enum logic [ALU_SEL_W-1:0] {
    ALU_AND = 3'd0,
    ALU_OR  = 3'd1,
    ALU_XOR = 3'd2,
    ALU_ADD = 3'd3,
    ALU_SUB = 3'd4,
    ALU_SLT = 3'd5,
    ALU_SLL = 3'd6,
    ALU_SRL = 3'd7
  } alu_op_e;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response channels of all requesters plus the shared-ALU drive bundle.
interface alu_share_arbiter_if
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned SEL_W = ALU_SEL_W,
  parameter int unsigned NREQ  = 2
);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*SEL_W-1:0] req_op;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic [NREQ*WIDTH-1:0] rsp_data;
  logic [NREQ-1:0]       rsp_err;
  logic [SEL_W-1:0]      alu_sel;
  logic [WIDTH-1:0]      alu_a;
  logic [WIDTH-1:0]      alu_b;
  logic [WIDTH-1:0]      alu_r;

  // Requesters and the external ALU together form the master side.
  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready, alu_r,
    input  req_ready, rsp_valid, rsp_data, rsp_err, alu_sel, alu_a, alu_b
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready, alu_r,
    output req_ready, rsp_valid, rsp_data, rsp_err, alu_sel, alu_a, alu_b
  );

endinterface

// File: rtl/alu_share_arbiter_rr_grant.sv
// Rotating-priority one-hot grant; pointer moves past the last winner.
module alu_share_arbiter_rr_grant #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] elig,
  output logic [NREQ-1:0] grant_c
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] win_idx;
  logic             win_any;
  int unsigned      sum;

  // Search ptr, ptr+1, ... modulo NREQ; first eligible index wins.
  always_comb begin
    grant_c = '0;
    win_idx = '0;
    win_any = 1'b0;
    cand    = '0;
    sum     = 0;
    for (int unsigned o = 0; o < NREQ; o++) begin
      sum  = 32'(ptr) + o;
      sum  = (sum >= NREQ) ? (sum - NREQ) : sum;
      cand = IDX_W'(sum);
      if (!win_any && elig[cand]) begin
        win_any       = 1'b1;
        grant_c[cand] = 1'b1;
        win_idx       = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (win_any) begin
      ptr <= (win_idx == IDX_W'(NREQ - 1)) ? '0 : (win_idx + IDX_W'(1));
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Arbitrates one shared combinational ALU among NREQ requesters, one op per cycle,
// and registers each result into the winner's response slot.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = ALU_WIDTH,
  parameter int unsigned SEL_W   = ALU_SEL_W,
  parameter int unsigned NREQ    = 2,
  parameter int unsigned NUM_OPS = ALU_NUM_OPS
) (
  input logic             clk,
  input logic             rst_n,
  alu_share_arbiter_if.slave bus
);

  localparam int unsigned CMP_W = SEL_W + 1;

  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] grant_c;
  logic            op_err_c;

  // A slot that is being drained this cycle may be refilled in the same cycle.
  assign elig          = bus.req_valid & (~bus.rsp_valid | bus.rsp_ready);
  assign bus.req_ready = grant_c;

  alu_share_arbiter_rr_grant #(.NREQ(NREQ)) u_rr_grant (
    .clk     (clk),
    .rst_n   (rst_n),
    .elig    (elig),
    .grant_c (grant_c)
  );

  // Mux the winner onto the ALU; hold everything at zero when idle.
  always_comb begin
    bus.alu_sel = '0;
    bus.alu_a   = '0;
    bus.alu_b   = '0;
    op_err_c    = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_c[i]) begin
        bus.alu_sel = bus.req_op[i*SEL_W +: SEL_W];
        bus.alu_a   = bus.req_a[i*WIDTH +: WIDTH];
        bus.alu_b   = bus.req_b[i*WIDTH +: WIDTH];
        op_err_c    = CMP_W'(bus.req_op[i*SEL_W +: SEL_W]) >= CMP_W'(NUM_OPS);
      end
    end
  end

  // Illegal ops still capture the ALU result; only the error flag differs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_valid <= '0;
      bus.rsp_data  <= '0;
      bus.rsp_err   <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (grant_c[i]) begin
          bus.rsp_valid[i]               <= 1'b1;
          bus.rsp_data[i*WIDTH +: WIDTH] <= bus.alu_r;
          bus.rsp_err[i]                 <= op_err_c;
        end else if (bus.rsp_ready[i]) begin
          bus.rsp_valid[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed checks of grant rotation, capture latency, back-pressure, illegal ops and reset.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int unsigned W = 32;
  localparam int unsigned S = 3;
  localparam int unsigned N = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_share_arbiter_if #(.WIDTH(W), .SEL_W(S), .NREQ(N)) bus ();

  alu_share_arbiter #(.WIDTH(W), .SEL_W(S), .NREQ(N), .NUM_OPS(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference ALU standing in for the external one.
  logic [W-1:0] alu_res;
  always_comb begin
    alu_res = '0;
    case (alu_op_e'(bus.alu_sel))
      ALU_AND: alu_res = bus.alu_a & bus.alu_b;
      ALU_OR:  alu_res = bus.alu_a | bus.alu_b;
      ALU_XOR: alu_res = bus.alu_a ^ bus.alu_b;
      ALU_ADD: alu_res = bus.alu_a + bus.alu_b;
      ALU_SUB: alu_res = bus.alu_a - bus.alu_b;
      ALU_SLT: alu_res = {31'b0, ($signed(bus.alu_a) < $signed(bus.alu_b))};
      ALU_SLL: alu_res = bus.alu_a << bus.alu_b[4:0];
      ALU_SRL: alu_res = bus.alu_a >> bus.alu_b[4:0];
      default: alu_res = '0;
    endcase
  end
  assign bus.alu_r = alu_res;

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int unsigned i, input logic v, input logic [S-1:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_valid[i]       = v;
    bus.req_op[i*S +: S]   = op;
    bus.req_a[i*W +: W]    = a;
    bus.req_b[i*W +: W]    = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Alternating-grant table: operands held by each requester per cycle.
  logic [S-1:0] t0_op [6] = '{ALU_ADD, ALU_XOR, ALU_XOR, ALU_SLT, ALU_SLT, ALU_SLT};
  logic [W-1:0] t0_a  [6] = '{32'd5, 32'hFF00, 32'hFF00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [W-1:0] t0_b  [6] = '{32'd7, 32'h0FF0, 32'h0FF0, 32'd1, 32'd1, 32'd1};
  logic         t0_v  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [S-1:0] t1_op [6] = '{ALU_SUB, ALU_SUB, ALU_OR, ALU_OR, ALU_SLL, ALU_SLL};
  logic [W-1:0] t1_a  [6] = '{32'd10, 32'd10, 32'd1, 32'd1, 32'd1, 32'd1};
  logic [W-1:0] t1_b  [6] = '{32'd3, 32'd3, 32'd2, 32'd2, 32'd4, 32'd4};
  logic [N-1:0] t_gnt [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
  logic [W-1:0] t_res [6] = '{32'hC, 32'd7, 32'hF0F0, 32'd3, 32'd1, 32'h10};

  logic [W-1:0] slot;

  initial begin
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = '0;

    // Reset and idle
    #12;
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    check("rst_rsp_data",  64'(bus.rsp_data),  64'h0);
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("idle_req_ready", 64'(bus.req_ready), 64'h0);
      check("idle_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    end
    check("idle_rsp_err", 64'(bus.rsp_err), 64'h0);
    check("idle_alu_sel", 64'(bus.alu_sel), 64'h0);
    check("idle_alu_a",   64'(bus.alu_a),   64'h0);
    check("idle_alu_b",   64'(bus.alu_b),   64'h0);

    // Single requester, AND
    drive(0, 1'b1, ALU_AND, 32'hF0F0_FFFF, 32'h0FF0_1234);
    #1;
    check("and_req_ready", 64'(bus.req_ready), 64'h1);
    check("and_alu_a", 64'(bus.alu_a), 64'hF0F0_FFFF);
    check("and_alu_b", 64'(bus.alu_b), 64'h0FF0_1234);
    tick();
    drive(0, 1'b0, ALU_AND, 32'h0, 32'h0);
    #1;
    check("and_rsp_valid", 64'(bus.rsp_valid), 64'h1);
    check("and_rsp_data",  64'(bus.rsp_data),  64'h0000_0000_00F0_1234);
    check("and_rsp_err",   64'(bus.rsp_err),   64'h0);

    // Both requesting: grants alternate from req0 after reset
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    bus.rsp_ready = 2'b11;
    for (int c = 0; c < 6; c++) begin
      drive(0, t0_v[c], t0_op[c], t0_a[c], t0_b[c]);
      drive(1, 1'b1, t1_op[c], t1_a[c], t1_b[c]);
      #1;
      check("alt_req_ready", 64'(bus.req_ready), 64'(t_gnt[c]));
      tick();
      check("alt_rsp_valid", 64'(bus.rsp_valid), 64'(t_gnt[c]));
      slot = (t_gnt[c] == 2'b01) ? bus.rsp_data[31:0] : bus.rsp_data[63:32];
      check("alt_rsp_data", 64'(slot), 64'(t_res[c]));
    end

    // Back-pressure on req0 leaves req1 free to use the ALU
    bus.rsp_ready = 2'b10;
    drive(0, 1'b1, ALU_ADD, 32'h100, 32'h23);
    drive(1, 1'b0, ALU_AND, 32'h0, 32'h0);
    #1;
    check("bp_first_grant", 64'(bus.req_ready), 64'h1);
    tick();
    drive(0, 1'b1, ALU_SUB, 32'h0, 32'h1);
    drive(1, 1'b1, ALU_AND, 32'hFF, 32'h0F);
    #1;
    check("bp_rsp_valid0", 64'(bus.rsp_valid), 64'h1);
    check("bp_rsp_data0",  64'(bus.rsp_data[31:0]), 64'h123);
    for (int k = 0; k < 3; k++) begin
      check("bp_req_ready", 64'(bus.req_ready), 64'h2);
      tick();
      check("bp_rsp_valid", 64'(bus.rsp_valid), 64'h3);
      check("bp_rsp_data",  64'(bus.rsp_data),  64'h0000_000F_0000_0123);
    end
    bus.rsp_ready = 2'b11;
    #1;
    check("bp_release_grant", 64'(bus.req_ready), 64'h1);
    tick();
    drive(0, 1'b0, ALU_AND, 32'h0, 32'h0);
    drive(1, 1'b0, ALU_AND, 32'h0, 32'h0);
    #1;
    check("bp_refill_valid", 64'(bus.rsp_valid), 64'h1);
    check("bp_refill_data",  64'(bus.rsp_data),  64'h0000_000F_FFFF_FFFF);

    // Illegal op 7 (NUM_OPS=7) still captures the result
    drive(1, 1'b1, 3'd7, 32'h8000_0000, 32'd4);
    #1;
    check("ill_req_ready", 64'(bus.req_ready), 64'h2);
    check("ill_alu_sel",   64'(bus.alu_sel),   64'h7);
    tick();
    check("ill_rsp_err",  64'(bus.rsp_err), 64'h2);
    check("ill_rsp_data", 64'(bus.rsp_data[63:32]), 64'h0800_0000);
    drive(1, 1'b1, ALU_ADD, 32'd1, 32'd1);
    #1;
    check("legal_req_ready", 64'(bus.req_ready), 64'h2);
    tick();
    check("legal_rsp_err",  64'(bus.rsp_err), 64'h0);
    check("legal_rsp_data", 64'(bus.rsp_data[63:32]), 64'h2);
    drive(1, 1'b0, ALU_AND, 32'h0, 32'h0);

    // Asynchronous reset with both slots full
    bus.rsp_ready = 2'b00;
    drive(0, 1'b1, ALU_XOR, 32'hA5A5_A5A5, 32'hFFFF_FFFF);
    #1;
    check("pre_rst_grant", 64'(bus.req_ready), 64'h1);
    tick();
    check("pre_rst_valid", 64'(bus.rsp_valid), 64'h3);
    check("pre_rst_data",  64'(bus.rsp_data[31:0]), 64'h5A5A_5A5A);
    drive(0, 1'b1, ALU_ADD, 32'd2, 32'd3);
    drive(1, 1'b1, ALU_OR, 32'hF0, 32'h0F);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(bus.rsp_valid), 64'h0);
    check("async_rst_data",  64'(bus.rsp_data),  64'h0);
    check("async_rst_err",   64'(bus.rsp_err),   64'h0);
    tick();
    check("in_rst_valid", 64'(bus.rsp_valid), 64'h0);
    @(negedge clk) rst_n = 1'b1;
    bus.rsp_ready = 2'b11;
    #1;
    check("post_rst_grant", 64'(bus.req_ready), 64'h1);
    tick();
    check("post_rst_valid", 64'(bus.rsp_valid), 64'h1);
    check("post_rst_data",  64'(bus.rsp_data[31:0]), 64'h5);
    drive(0, 1'b0, ALU_AND, 32'h0, 32'h0);
    #1;
    check("post_rst_grant1", 64'(bus.req_ready), 64'h2);
    tick();
    drive(1, 1'b0, ALU_AND, 32'h0, 32'h0);
    check("post_rst_valid1", 64'(bus.rsp_valid), 64'h2);
    check("post_rst_data1",  64'(bus.rsp_data[63:32]), 64'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
